// File: rtl/irq_timer_ctrl.sv
// Interrupt source block: compare/auto-reload timer plus NUM_EXT rising-edge lines feeding a
// pending/enable set and a fixed-priority valid/ack presenter. Optional: IRQ_TIMER_PRESCALER_EN.
module irq_timer_ctrl #(
    parameter int unsigned TMR_WIDTH   = 16,
    parameter int unsigned NUM_EXT     = 3,
    parameter int unsigned PRESC_WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         timer_en,
    input  logic                         cmp_we,
    input  logic [TMR_WIDTH-1:0]         cmp_wdata,
    input  logic [PRESC_WIDTH-1:0]       presc_wdata,
    input  logic [NUM_EXT-1:0]           ext_irq,
    input  logic                         en_we,
    input  logic [NUM_EXT:0]             en_wdata,
    input  logic                         irq_ack,
    output logic                         irq_valid,
    output logic [$clog2(NUM_EXT+1)-1:0] irq_id,
    output logic [NUM_EXT:0]             irq_onehot,
    output logic [NUM_EXT:0]             pending,
    output logic [TMR_WIDTH-1:0]         tmr_count
);
    localparam int unsigned NUM_SRC  = NUM_EXT + 1;
    localparam int unsigned ID_WIDTH = $clog2(NUM_SRC);

    typedef enum logic {StIdle, StPresent} state_t;

    state_t               state;
    logic [TMR_WIDTH-1:0] cmp;
    logic [NUM_SRC-1:0]   enable;
    logic [NUM_EXT-1:0]   ext_q;
    logic                 tick;
    logic                 tmr_match;
    logic [NUM_SRC-1:0]   set_mask;
    logic [NUM_SRC-1:0]   clr_mask;
    logic [NUM_SRC-1:0]   req;
    logic [ID_WIDTH-1:0]  win_id;

`ifdef IRQ_TIMER_PRESCALER_EN
    logic [PRESC_WIDTH-1:0] presc;
    logic [PRESC_WIDTH-1:0] presc_cnt;

    assign tick = timer_en && (presc_cnt == presc);

    always_ff @(posedge clk) begin
        if (rst) begin
            presc     <= '0;
            presc_cnt <= '0;
        end else if (cmp_we) begin
            presc     <= presc_wdata;
            presc_cnt <= '0;
        end else if (timer_en) begin
            if (presc_cnt == presc) begin
                presc_cnt <= '0;
            end else begin
                presc_cnt <= presc_cnt + 1'b1;
            end
        end
    end
`else
    logic unused_presc;
    assign unused_presc = ^presc_wdata;
    assign tick         = timer_en;
`endif

    // A compare write in the same cycle suppresses the match.
    assign tmr_match = tick && !cmp_we && (tmr_count == cmp);

    always_ff @(posedge clk) begin
        if (rst) begin
            tmr_count <= '0;
            cmp       <= '0;
        end else if (cmp_we) begin
            cmp       <= cmp_wdata;
            tmr_count <= '0;
        end else if (tick) begin
            if (tmr_count == cmp) begin
                tmr_count <= '0;
            end else begin
                tmr_count <= tmr_count + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ext_q <= '0;
        end else begin
            ext_q <= ext_irq;
        end
    end

    assign set_mask = {ext_irq & ~ext_q, tmr_match};
    assign clr_mask = (state == StPresent && irq_ack) ? irq_onehot : '0;
    assign req      = pending & enable;

    // Lowest index wins, so scan downward and let later hits overwrite.
    always_comb begin
        win_id = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                win_id = ID_WIDTH'(i);
            end
        end
    end

    // Set has priority over a same-cycle acknowledge clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~clr_mask) | set_mask;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            enable <= '1;
        end else if (en_we) begin
            enable <= en_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= StIdle;
            irq_valid  <= 1'b0;
            irq_id     <= '0;
            irq_onehot <= '0;
        end else begin
            case (state)
                StIdle: begin
                    if (|req) begin
                        state      <= StPresent;
                        irq_valid  <= 1'b1;
                        irq_id     <= win_id;
                        irq_onehot <= NUM_SRC'(1) << win_id;
                    end
                end
                StPresent: begin
                    if (irq_ack) begin
                        state      <= StIdle;
                        irq_valid  <= 1'b0;
                        irq_onehot <= '0;
                    end
                end
            endcase
        end
    end
endmodule
